// File: rtl/apb_rr_arbiter.sv
// rtl/apb_rr_arbiter.sv - round-robin arbiter sharing one APB master port between requesters
//
// Ports:
//   clk, reset                 clock; synchronous active-high reset
//   req_i / req_write_i        per-requester level request and direction (1 = write)
//   req_addr_i / req_wdata_i   packed payloads, requester k at [32k+31:32k]
//   done_o / rdata_o / err_o   one-cycle completion pulse (one-hot), read data, timeout flag
//   apb_*                      APB master port (psel, penable, paddr, pwrite, pwdata, prdata, pready)
module apb_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 256
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_REQ-1:0]      req_i,
    input  logic [NUM_REQ-1:0]      req_write_i,
    input  logic [NUM_REQ*32-1:0]   req_addr_i,
    input  logic [NUM_REQ*32-1:0]   req_wdata_i,
    output logic [NUM_REQ-1:0]      done_o,
    output logic [31:0]             rdata_o,
    output logic                    err_o,
    output logic                    apb_psel_o,
    output logic                    apb_penable_o,
    output logic [31:0]             apb_paddr_o,
    output logic                    apb_pwrite_o,
    output logic [31:0]             apb_pwdata_o,
    input  logic [31:0]             apb_prdata_i,
    input  logic                    apb_pready_i
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] T_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_SETUP  = 2'b01,
        S_ACCESS = 2'b10
    } state_t;

    state_t          state, state_next;
    logic [IW-1:0]   rr_ptr;
    logic [IW-1:0]   win_q;
    logic [IW-1:0]   win_next;
    logic            win_found;
    logic [31:0]     addr_q;
    logic [31:0]     wdata_q;
    logic            write_q;
    logic [CW-1:0]   tcnt;

    logic            grant;
    logic            complete;
    logic            timed_out;
    logic            resp_valid;

    // Rotating priority: the requester just after the last winner is looked at first.
    always_comb begin
        int idx;
        idx       = 0;
        win_found = 1'b0;
        win_next  = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = (int'(rr_ptr) + i) % NUM_REQ;
            if (!win_found && req_i[idx]) begin
                win_found = 1'b1;
                win_next  = IW'(idx);
            end
        end
    end

    always_comb begin
        state_next    = S_IDLE;
        grant         = 1'b0;
        complete      = 1'b0;
        timed_out     = 1'b0;
        apb_psel_o    = 1'b0;
        apb_penable_o = 1'b0;
        apb_paddr_o   = '0;
        apb_pwrite_o  = 1'b0;
        apb_pwdata_o  = '0;
        case (state)
            S_IDLE: begin
                if (win_found) begin
                    grant      = 1'b1;
                    state_next = S_SETUP;
                end
            end
            S_SETUP: begin
                apb_psel_o   = 1'b1;
                apb_paddr_o  = addr_q;
                apb_pwrite_o = write_q;
                apb_pwdata_o = write_q ? wdata_q : '0;
                state_next   = S_ACCESS;
            end
            S_ACCESS: begin
                apb_psel_o    = 1'b1;
                apb_penable_o = 1'b1;
                apb_paddr_o   = addr_q;
                apb_pwrite_o  = write_q;
                apb_pwdata_o  = write_q ? wdata_q : '0;
                state_next    = S_ACCESS;
                if (apb_pready_i) begin
                    complete   = 1'b1;
                    state_next = S_IDLE;
                end else if (TIMEOUT != 0 && tcnt == T_LAST) begin
                    complete   = 1'b1;
                    timed_out  = 1'b1;
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // A completion coinciding with reset is discarded: the transfer is being torn down.
    assign resp_valid = complete && !reset;
    assign done_o     = resp_valid ? (NUM_REQ'(1) << win_q) : '0;
    assign err_o      = resp_valid && timed_out;
    assign rdata_o    = (resp_valid && !timed_out && !write_q) ? apb_prdata_i : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            rr_ptr  <= IW'(NUM_REQ - 1);
            win_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
            tcnt    <= '0;
        end else begin
            state <= state_next;
            if (grant) begin
                win_q   <= win_next;
                addr_q  <= req_addr_i[32*int'(win_next) +: 32];
                wdata_q <= req_wdata_i[32*int'(win_next) +: 32];
                write_q <= req_write_i[win_next];
            end
            if (complete) begin
                rr_ptr <= win_q;
            end
            if (state == S_ACCESS && state_next == S_ACCESS) begin
                tcnt <= tcnt + CW'(1);
            end else begin
                tcnt <= '0;
            end
        end
    end

endmodule
